// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: state encoding and default debounce depth.
package btn_pkg;

    // Bit 1 of the encoding is the debounced level.
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ARMING    = 2'b01,
        HELD      = 2'b11,
        RELEASING = 2'b10
    } btn_state_e;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, consecutive-sample debounce FSM, level and edge pulses.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_level_nxt,
    output logic o_press,
    output logic o_release
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    btn_state_e       r_state;
    logic             r_press;
    logic             r_release;
    logic             w_level_nxt;

    // Level the FSM will hold after the coming edge; lets the top register conflict in step.
    always_comb begin
        w_level_nxt = r_state[1];
        if (r_state == ARMING && r_sync2 && r_cnt == CNT_LAST) begin
            w_level_nxt = 1'b1;
        end else if (r_state == RELEASING && !r_sync2 && r_cnt == CNT_LAST) begin
            w_level_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_cnt     <= '0;
            r_state   <= IDLE;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (r_sync2) begin
                        r_state <= ARMING;
                        r_cnt   <= CNT_W'(1);
                    end else begin
                        r_cnt <= '0;
                    end
                end
                ARMING: begin
                    if (!r_sync2) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!r_sync2) begin
                        r_state <= RELEASING;
                        r_cnt   <= CNT_W'(1);
                    end else begin
                        r_cnt <= '0;
                    end
                end
                RELEASING: begin
                    if (r_sync2) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_level     = r_state[1];
    assign o_level_nxt = w_level_nxt;
    assign o_press     = r_press;
    assign o_release   = r_release;

endmodule

// File: rtl/button_conditioner.sv
// Two independent debounced button channels plus a registered both-held conflict flag.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn1_raw,
    input  logic btn2_raw,
    output logic B1,
    output logic B2,
    output logic b1_press,
    output logic b2_press,
    output logic b1_release,
    output logic b2_release,
    output logic conflict
);

    logic w_lvl1_nxt;
    logic w_lvl2_nxt;
    logic r_conflict;

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_raw      (btn1_raw),
        .o_level    (B1),
        .o_level_nxt(w_lvl1_nxt),
        .o_press    (b1_press),
        .o_release  (b1_release)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_raw      (btn2_raw),
        .o_level    (B2),
        .o_level_nxt(w_lvl2_nxt),
        .o_press    (b2_press),
        .o_release  (b2_release)
    );

    // Registered from the next levels so it changes on the same edge as B1/B2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict <= 1'b0;
        end else begin
            r_conflict <= w_lvl1_nxt & w_lvl2_nxt;
        end
    end

    assign conflict = r_conflict;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4 and a 10 ns clock.
module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst_n;
    logic btn1_raw;
    logic btn2_raw;
    logic B1, B2, b1_press, b2_press, b1_release, b2_release, conflict;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn1_raw  (btn1_raw),
        .btn2_raw  (btn2_raw),
        .B1        (B1),
        .B2        (B2),
        .b1_press  (b1_press),
        .b2_press  (b2_press),
        .b1_release(b1_release),
        .b2_release(b2_release),
        .conflict  (conflict)
    );

    always #5 clk = ~clk;

    wire [6:0] w_outs = {B1, B2, b1_press, b2_press, b1_release, b2_release, conflict};

    function automatic logic [6:0] exp_vec(input logic b1, input logic b2, input logic p1,
                                           input logic p2, input logic r1, input logic r2,
                                           input logic cf);
        return {b1, b2, p1, p2, r1, r2, cf};
    endfunction

    // Vector order: {B1,B2,b1_press,b2_press,b1_release,b2_release,conflict}
    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        btn1_raw = 1'b0;
        btn2_raw = 1'b0;

        // Reset with toggling raw inputs
        for (int i = 0; i < 6; i++) begin
            btn1_raw = ~btn1_raw;
            btn2_raw = (i % 3 == 0);
            #7;
            check("reset_toggle", w_outs, 7'b0);
        end
        tick();
        btn1_raw = 1'b0;
        btn2_raw = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("post_reset_idle", w_outs, 7'b0);
        end

        // Clean press on button 1: level rises on edge 6
        btn1_raw = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check("press1", w_outs, exp_vec(e >= 6, 0, e == 6, 0, 0, 0, 0));
        end

        // Bounce on button 2 while button 1 is held: never accepted
        for (int i = 0; i < 14; i++) begin
            btn2_raw = (i < 3) || (i == 4) || (i == 5);
            tick();
            check("bounce2", w_outs, exp_vec(1, 0, 0, 0, 0, 0, 0));
        end

        // Two-cycle low glitch while HELD
        for (int i = 0; i < 12; i++) begin
            btn1_raw = !(i < 2);
            tick();
            check("glitch1", w_outs, exp_vec(1, 0, 0, 0, 0, 0, 0));
        end

        // Release of button 1
        btn1_raw = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check("release1", w_outs, exp_vec(e < 6, 0, 0, 0, e == 6, 0, 0));
        end

        // Simultaneous press, then release of button 2 clears conflict
        btn1_raw = 1'b1;
        btn2_raw = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check("simul_press", w_outs, exp_vec(e >= 6, e >= 6, e == 6, e == 6, 0, 0, e >= 6));
        end
        btn2_raw = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check("simul_rel2", w_outs, exp_vec(1, e < 6, 0, 0, 0, e == 6, e < 6));
        end

        // Asynchronous reset while B1 held, X on a raw input during reset
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", w_outs, 7'b0);
        btn2_raw = 1'bx;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold_x", w_outs, 7'b0);
        end
        btn2_raw = 1'b0;
        rst_n    = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check("repress_after_reset", w_outs, exp_vec(e >= 6, 0, e == 6, 0, 0, 0, 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
